// File: rtl/rtc_bus_sequencer.sv
// Purpose: burst sequencer for the external RTC multiplexed address/data bus (CS/RD/WR/AD, tristate data).
// Latency: CS falls 1 cycle after start; 2*(T_SU+T_PW+T_H) cycles per access, T_GAP between accesses; done 1 cycle after the last D_H.
// Backpressure: none; start is ignored while busy. Optional abort input/aborted output under `RTC_BURST_ABORT_EN.
module rtc_bus_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8,
    parameter int T_SU      = 1,
    parameter int T_PW      = 2,
    parameter int T_H       = 1,
    parameter int T_GAP     = 1,
    localparam int CW       = $clog2(MAX_BURST + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CW-1:0]     count,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
`ifdef RTC_BURST_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic              CS,
    output logic              RD,
    output logic              WR,
    output logic              AD
);

    // Dwell counter only has to hold (longest phase - 1); FIN from IDLE needs a value of 1.
    localparam int TMAX0 = (T_SU  > T_PW)  ? T_SU  : T_PW;
    localparam int TMAX1 = (TMAX0 > T_H)   ? TMAX0 : T_H;
    localparam int TMAX2 = (TMAX1 > T_GAP) ? TMAX1 : T_GAP;
    localparam int TMAX  = (TMAX2 > 2)     ? TMAX2 : 2;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SU,
        S_A_PW,
        S_A_H,
        S_D_SU,
        S_D_PW,
        S_D_H,
        S_GAP,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_tmr;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_rem;

    logic              r_cs;
    logic              r_rd;
    logic              r_wr;
    logic              r_ad;
    logic              r_oe;
    logic [DATA_W-1:0] r_bus_out;
    logic              r_wd_ack;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_busy;
    logic              r_done;

    state_t            w_nxt_state;
    logic [TW-1:0]     w_nxt_tmr;
    logic              w_nxt_rw;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [CW-1:0]     w_nxt_rem;
    logic              w_tmr_done;
    logic              w_stop;
    logic              w_nxt_aph;
    logic              w_nxt_dph;
    logic              w_nxt_done;
    logic              w_rd_cap;

    function automatic logic [TW-1:0] dwell_m1(input state_t s);
        case (s)
            S_A_SU, S_D_SU: dwell_m1 = TW'(T_SU - 1);
            S_A_PW, S_D_PW: dwell_m1 = TW'(T_PW - 1);
            S_A_H,  S_D_H:  dwell_m1 = TW'(T_H - 1);
            S_GAP:          dwell_m1 = TW'(T_GAP - 1);
            default:        dwell_m1 = '0;
        endcase
    endfunction

`ifdef RTC_BURST_ABORT_EN
    logic r_abt_pend;
    logic r_aborted;
    assign w_stop  = r_abt_pend | abort;
    assign aborted = r_aborted;

    // Latch an abort request for the rest of the burst; cleared when a new burst is accepted.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_abt_pend <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            if (r_state == S_IDLE)
                r_abt_pend <= 1'b0;
            else if (abort && r_state != S_FIN)
                r_abt_pend <= 1'b1;
            r_aborted <= w_nxt_done && w_stop && (r_state == S_D_H || r_state == S_GAP);
        end
    end
`else
    assign w_stop = 1'b0;
`endif

    // Next-state, dwell timer and burst bookkeeping.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_rw    = r_rw;
        w_nxt_addr  = r_addr;
        w_nxt_rem   = r_rem;
        w_nxt_tmr   = r_tmr;
        w_tmr_done  = (r_tmr == '0);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_rw    = rw;
                    w_nxt_addr  = base_addr;
                    w_nxt_rem   = count;
                    w_nxt_state = (count != '0) ? S_A_SU : S_FIN;
                end
            end
            S_A_SU: if (w_tmr_done) w_nxt_state = S_A_PW;
            S_A_PW: if (w_tmr_done) w_nxt_state = S_A_H;
            S_A_H:  if (w_tmr_done) w_nxt_state = S_D_SU;
            S_D_SU: if (w_tmr_done) w_nxt_state = S_D_PW;
            S_D_PW: if (w_tmr_done) w_nxt_state = S_D_H;
            S_D_H: begin
                if (w_tmr_done) begin
                    w_nxt_addr  = r_addr + ADDR_W'(1);
                    w_nxt_rem   = r_rem - CW'(1);
                    w_nxt_state = (r_rem == CW'(1) || w_stop) ? S_FIN : S_GAP;
                end
            end
            S_GAP:  if (w_tmr_done) w_nxt_state = w_stop ? S_FIN : S_A_SU;
            S_FIN:  if (w_tmr_done) w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
        // An empty burst dwells one extra cycle in FIN so done lands two cycles after start.
        if (w_nxt_state != r_state)
            w_nxt_tmr = (r_state == S_IDLE && w_nxt_state == S_FIN) ? TW'(1) : dwell_m1(w_nxt_state);
        else if (!w_tmr_done)
            w_nxt_tmr = r_tmr - TW'(1);
        else
            w_nxt_tmr = '0;
    end

    assign w_nxt_aph  = (w_nxt_state == S_A_SU) || (w_nxt_state == S_A_PW) || (w_nxt_state == S_A_H);
    assign w_nxt_dph  = (w_nxt_state == S_D_SU) || (w_nxt_state == S_D_PW) || (w_nxt_state == S_D_H);
    assign w_nxt_done = (w_nxt_state == S_FIN) && (w_nxt_tmr == '0);
    assign w_rd_cap   = (r_state == S_D_PW) && w_tmr_done && r_rw;

    // FSM state register with all pin/handshake outputs registered from the next state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_cs       <= 1'b1;
            r_rd       <= 1'b1;
            r_wr       <= 1'b1;
            r_ad       <= 1'b1;
            r_oe       <= 1'b0;
            r_bus_out  <= '0;
            r_wd_ack   <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_tmr   <= w_nxt_tmr;
            r_rw    <= w_nxt_rw;
            r_addr  <= w_nxt_addr;
            r_rem   <= w_nxt_rem;

            r_cs <= !(w_nxt_aph || w_nxt_dph);
            r_ad <= !w_nxt_aph;
            r_wr <= !((w_nxt_state == S_A_PW) || (w_nxt_state == S_D_PW && !w_nxt_rw));
            r_rd <= !(w_nxt_state == S_D_PW && w_nxt_rw);
            // Read data phase never drives the bus, so RD low and bus_oe high cannot coexist.
            r_oe <= w_nxt_aph || (w_nxt_dph && !w_nxt_rw);

            // Address is driven through the address phase; write data replaces it once acked.
            if (w_nxt_aph)
                r_bus_out <= DATA_W'(w_nxt_addr);
            else if (r_wd_ack)
                r_bus_out <= wr_data;

            r_wd_ack <= (r_state == S_A_H) && (w_nxt_state == S_D_SU) && !r_rw;

            if (w_rd_cap)
                r_rd_data <= bus_in;
            r_rd_valid <= w_rd_cap;

            r_busy <= (w_nxt_state != S_IDLE);
            r_done <= w_nxt_done;
        end
    end

    assign CS       = r_cs;
    assign RD       = r_rd;
    assign WR       = r_wr;
    assign AD       = r_ad;
    assign bus_oe   = r_oe;
    assign bus_out  = r_bus_out;
    assign wd_ack   = r_wd_ack;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: table of bursts plus hand-written reset, write-trace, busy/reset and abort sequences.
// The RTC is modelled as latching the address on the address-phase WR strobe and returning addr^0xA5 while RD is low.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_rtc_bus_sequencer;

    logic       CLK;
    logic       RST;
    logic       start;
    logic       rw;
    logic [7:0] base_addr;
    logic [3:0] count;
    logic [7:0] wr_data;
    logic       wd_ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;
    logic       CS;
    logic       RD;
    logic       WR;
    logic       AD;
`ifdef RTC_BURST_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    rtc_bus_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .rw        (rw),
        .base_addr (base_addr),
        .count     (count),
        .wr_data   (wr_data),
        .wd_ack    (wd_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
`ifdef RTC_BURST_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .bus_in    (bus_in),
        .CS        (CS),
        .RD        (RD),
        .WR        (WR),
        .AD        (AD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RTC model
    logic [7:0] rtc_lat;
    initial rtc_lat = 8'h00;
    always @(posedge CLK) if (!CS && !AD && !WR) rtc_lat <= bus_out;
    assign bus_in = !RD ? (rtc_lat ^ 8'hA5) : 8'h00;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Burst observations
    logic [7:0]  addrq[$];
    logic [7:0]  wrq[$];
    logic [7:0]  rdq[$];
    int          n_acc, n_ack, n_rdv, n_viol, done_k;
    logic        busy_after, abt_seen;
    logic [15:0] v_cs, v_ad, v_wr, v_rd, v_oe, v_ack, v_done, v_busy;
    logic [7:0]  tr_bus[16];

    task automatic trace(input int k);
        if (k < 16) begin
            v_cs[k]   = CS;
            v_ad[k]   = AD;
            v_wr[k]   = WR;
            v_rd[k]   = RD;
            v_oe[k]   = bus_oe;
            v_ack[k]  = wd_ack;
            v_done[k] = done;
            v_busy[k] = busy;
            tr_bus[k] = bus_out;
        end
    endtask

    task automatic run_burst(input logic i_rw, input logic [7:0] i_base, input logic [3:0] i_cnt,
                             input logic [7:0] i_wdat, input int abort_k);
        logic prev_cs, prev_wr;
        addrq.delete(); wrq.delete(); rdq.delete();
        n_acc = 0; n_ack = 0; n_rdv = 0; n_viol = 0; done_k = -1;
        busy_after = 1'b1; abt_seen = 1'b0;
        v_cs = '1; v_ad = '1; v_wr = '1; v_rd = '1; v_oe = '0; v_ack = '0; v_done = '0; v_busy = '0;
        @(negedge CLK);
        trace(0);
        rw = i_rw; base_addr = i_base; count = i_cnt; wr_data = i_wdat; start = 1'b1;
        prev_cs = CS; prev_wr = WR;
        for (int k = 1; k <= 250 && done_k < 0; k++) begin
            @(negedge CLK);
            start = 1'b0;
`ifdef RTC_BURST_ABORT_EN
            abort = (k == abort_k);
`endif
            trace(k);
            if (prev_cs && !CS) n_acc++;
            if (!CS && !AD && !WR && prev_wr) addrq.push_back(bus_out);
            if (!CS && AD && !WR && prev_wr) wrq.push_back(bus_out);
            if (rd_valid) begin n_rdv++; rdq.push_back(rd_data); end
            if (wd_ack) begin n_ack++; wr_data = i_wdat + 8'(n_ack - 1); end
            if ((!RD && !WR) || (bus_oe && !RD)) n_viol++;
            if (done) begin
                done_k = k;
`ifdef RTC_BURST_ABORT_EN
                abt_seen = aborted;
`endif
            end
            prev_cs = CS; prev_wr = WR;
        end
        @(negedge CLK);
        busy_after = busy;
`ifdef RTC_BURST_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    typedef struct {
        logic       rw;
        logic [7:0] base;
        logic [3:0] cnt;
        logic [7:0] wdat;
        int         exp_done;
    } vec_t;

    localparam int NV = 6;
    vec_t vt[NV];

    initial begin
        int bad;
        RST = 1'b0; start = 1'b0; rw = 1'b0; base_addr = '0; count = '0; wr_data = '0;
`ifdef RTC_BURST_ABORT_EN
        abort = 1'b0;
`endif
        vt[0] = '{1'b0, 8'h21, 4'd1, 8'h59, 9};
        vt[1] = '{1'b1, 8'hFE, 4'd3, 8'h00, 27};
        vt[2] = '{1'b0, 8'h00, 4'd0, 8'h77, 2};
        vt[3] = '{1'b0, 8'hFF, 4'd2, 8'h3C, 18};
        vt[4] = '{1'b1, 8'h10, 4'd8, 8'h00, 72};
        vt[5] = '{1'b1, 8'h80, 4'd1, 8'h00, 9};

        // Reset values
        repeat (3) @(negedge CLK);
        chk("reset CS/RD/WR/AD", {28'd0, CS, RD, WR, AD}, 32'hF);
        chk("reset bus_oe", bus_oe, 0);
        chk("reset bus_out", bus_out, 0);
        chk("reset busy/done/rd_valid/wd_ack", {busy, done, rd_valid, wd_ack}, 0);
        chk("reset rd_data", rd_data, 0);

        // Idle 20 cycles after reset release
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if ({CS, RD, WR, AD} != 4'hF || bus_oe || busy || done || wd_ack || rd_valid) bad++;
        end
        chk("idle cycles with activity", bad, 0);

        // Table of bursts
        for (int r = 0; r < NV; r++) begin
            run_burst(vt[r].rw, vt[r].base, vt[r].cnt, vt[r].wdat, -1);
            chk($sformatf("row%0d done cycle", r), done_k, vt[r].exp_done);
            chk($sformatf("row%0d accesses", r), n_acc, vt[r].cnt);
            chk($sformatf("row%0d wd_ack count", r), n_ack, vt[r].rw ? 0 : vt[r].cnt);
            chk($sformatf("row%0d rd_valid count", r), n_rdv, vt[r].rw ? vt[r].cnt : 0);
            chk($sformatf("row%0d strobe violations", r), n_viol, 0);
            chk($sformatf("row%0d busy after done", r), busy_after, 0);
            chk($sformatf("row%0d address strobes", r), addrq.size(), vt[r].cnt);
            for (int i = 0; i < addrq.size(); i++)
                chk($sformatf("row%0d addr[%0d]", r, i), addrq[i], 8'(vt[r].base + 8'(i)));
            if (vt[r].rw) begin
                for (int i = 0; i < rdq.size(); i++)
                    chk($sformatf("row%0d rd[%0d]", r, i), rdq[i], 8'(vt[r].base + 8'(i)) ^ 8'hA5);
            end else begin
                chk($sformatf("row%0d write strobes", r), wrq.size(), vt[r].cnt);
                for (int i = 0; i < wrq.size(); i++)
                    chk($sformatf("row%0d wr[%0d]", r, i), wrq[i], 8'(vt[r].wdat + 8'(i)));
            end
`ifdef RTC_BURST_ABORT_EN
            chk($sformatf("row%0d aborted", r), abt_seen, 0);
`endif
            if (r == 0) begin
                // Single write, defaults: cycle-exact pin trace
                chk("write CS trace", v_cs, 16'hFE01);
                chk("write AD trace", v_ad, 16'hFFE1);
                chk("write WR trace", v_wr, 16'hFF33);
                chk("write RD trace", v_rd, 16'hFFFF);
                chk("write bus_oe trace", v_oe, 16'h01FE);
                chk("write wd_ack trace", v_ack, 16'h0020);
                chk("write done trace", v_done, 16'h0200);
                chk("write busy trace", v_busy, 16'h03FE);
                chk("write addr on bus c2", tr_bus[2], 8'h21);
                chk("write data on bus c6", tr_bus[6], 8'h59);
            end
            if (r == 2) chk("empty burst CS trace", v_cs, 16'hFFFF);
            if (r == 3) chk("rd_data held across write", rd_data, 8'hA5);
        end

        // Start while busy is ignored, then reset mid D_PW
        @(negedge CLK);
        rw = 1'b1; base_addr = 8'h30; count = 4'd2; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        @(negedge CLK); rw = 1'b0; base_addr = 8'h40; count = 4'd3; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        chk("busy start: addr kept", bus_out, 8'h30);
        chk("busy start: still addr phase", AD, 0);
        @(negedge CLK);
        chk("busy start: read oe off", bus_oe, 0);
        chk("busy start: no wd_ack", wd_ack, 0);
        @(negedge CLK);
        chk("read D_PW RD low", RD, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid-burst reset pins", {28'd0, CS, RD, WR, AD}, 32'hF);
        chk("mid-burst reset oe", bus_oe, 0);
        chk("mid-burst reset busy", busy, 0);
        chk("mid-burst reset done", done, 0);
        @(negedge CLK);
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (done || !CS || busy) bad++;
        end
        chk("after reset no resume/done", bad, 0);

`ifdef RTC_BURST_ABORT_EN
        // Abort during the second access of a 5-write burst
        run_burst(1'b0, 8'h50, 4'd5, 8'h10, 12);
        chk("abort wd_ack count", n_ack, 2);
        chk("abort accesses", n_acc, 2);
        chk("abort done cycle", done_k, 18);
        chk("abort aborted flag", abt_seen, 1);
        chk("abort busy after", busy_after, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
Parametrised successor to the RTC transfer engine. It drives the multiplexed address/data bus of the external RTC (CS, RD, WR, AD, bidirectional data) with programmable phase timing. It runs bursts of 1..MAX_BURST consecutive register accesses from one start request, in read or write mode. It sits between the menu/master FSM and the RTC pins, replacing the fixed single-access transfer block.

Parameters:
ADDR_W, 8, register address width; address wraps modulo 2^ADDR_W
DATA_W, 8, bus data width (must be >= ADDR_W)
MAX_BURST, 8, maximum accesses per burst; count width CW = clog2(MAX_BURST+1)
T_SU, 1, cycles of setup before a strobe (>=1)
T_PW, 2, cycles of strobe low (>=1)
T_H, 1, cycles of hold after a strobe (>=1)
T_GAP, 1, cycles with CS high between accesses (>=1)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous reset, active-low
start  in  1  one-cycle burst request; ignored while busy=1
rw  in  1  1 = read burst, 0 = write burst; captured with start
base_addr  in  ADDR_W  first register address; captured with start
count  in  CW  number of accesses; captured with start
wr_data  in  DATA_W  write byte; must be valid in the cycle wd_ack=1
wd_ack  out  1  one-cycle pulse: wr_data sampled for the current access
rd_data  out  DATA_W  last byte read; held until the next read
rd_valid  out  1  one-cycle pulse: rd_data updated
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at burst end
bus_out  out  DATA_W  value driven on the external data bus
bus_oe  out  1  1 = FPGA drives the bus (tristate enable)
bus_in  in  DATA_W  external data bus readback
CS  out  1  chip select, active-low
RD  out  1  read strobe, active-low
WR  out  1  write strobe, active-low
AD  out  1  0 = address phase, 1 = data phase

Behaviour:
- Reset (RST=0 at an edge): state IDLE; CS=RD=WR=AD=1; bus_oe=0; bus_out=0; busy=done=rd_valid=wd_ack=0; rd_data=0. Reset mid-burst aborts at that same edge: strobes deasserted, bus released, no done pulse.
- States: IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, GAP, FIN. A per-phase down-counter sets dwell: A_SU/D_SU = T_SU, A_PW/D_PW = T_PW, A_H/D_H = T_H, GAP = T_GAP cycles.
- IDLE: when start=1 and count!=0, capture rw, base_addr and count, then go to A_SU. When start=1 and count=0, go to FIN (done pulses 1 cycle later; no bus activity).
- A_SU/A_PW/A_H: CS=0, AD=0, bus_oe=1, bus_out = zero-extended address. WR=0 only in A_PW. RD=1.
- D_SU: CS=0, AD=1.
  - Write: bus_oe=1; wr_data is sampled on the first D_SU cycle, with wd_ack=1 that cycle; bus_out holds the sample through D_H.
  - Read: bus_oe=0 from D_SU through D_H.
- D_PW: write asserts WR=0; read asserts RD=0. For a read, bus_in is captured on the last D_PW cycle; rd_data and rd_valid=1 update on the next cycle.
- D_H: strobes high, CS=0. Exit: decrement remaining count and increment address (wrap 2^ADDR_W-1 -> 0). If remaining count is 0, go to FIN; otherwise go to GAP.
- GAP: CS=1, AD=1, bus_oe=0; then A_SU.
- FIN: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Timing:
  - Access length = 2*(T_SU+T_PW+T_H) cycles, plus T_GAP between accesses.
  - Defaults: 8 cycles per access, 9-cycle pitch.
  - CS falls 1 cycle after start. done occurs 1 cycle after the final D_H.
- Never: RD and WR both low; bus_oe=1 while RD=0.

Optional Feature:
Macro: RTC_BURST_ABORT_EN.
- Defined: adds input abort (1 bit). If abort=1 in any cycle while busy, the current access completes through D_H, then the sequencer goes to FIN regardless of remaining count. done pulses as normal, and an extra output aborted (1 bit) is high with done.
- Undefined: neither port exists; every burst runs to its full count.

Test Plan:
- Reset release, idle 20 cycles -> CS=RD=WR=AD=1, bus_oe=0, busy=0, no strobes.
- Write, base_addr=0x21, count=1, wr_data=0x59, defaults:
  - CS low for cycles 1..8; AD=0 during cycles 1..4; WR low cycles 2..3 with bus_out=0x21.
  - wd_ack at cycle 5; WR low cycles 6..7 with bus_out=0x59; done at cycle 9.
- Read burst, base_addr=0xFE, count=3, bus_in model returns addr^0xA5 -> rd_valid ×3 with 0x5B, 0x5A, 0xA5; addresses 0xFE, 0xFF, 0x00 (wrap); CS high between accesses; done once.
- start with count=0 -> no CS activity; done pulse 2 cycles after start.
- start reasserted while busy; RST=0 asserted mid-D_PW -> second start ignored; on reset edge all strobes high, bus_oe=0, no done.
- RTC_BURST_ABORT_EN: write count=5, abort during access 2 -> exactly 2 wd_ack, done with aborted=1.
